id_ex_flush_ctrl: RTL and testbench

ID_EX_FLUSH_CTRL -- requirements
Module: id_ex_flush_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/npu_watchdog.sv | 35 +++
 rtl/id_ex_flush_ctrl.sv | 115 +++++++++++
 tb/tb_id_ex_flush_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the ID/EX flush controller and its NPU watchdog:
// FSM state encoding, counter widths and the counter type.
package pipe_ctrl_pkg;

  // Flush and NPU-ack counters. The parameter ranges (1..15) keep them from wrapping.
  localparam int CNT_W = 4;

  // NPU watchdog cycle counter width.
  localparam int WD_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    NPU_RUN = 2'd2
  } state_t;

endpackage

// File: rtl/npu_watchdog.sv
// NPU sequence watchdog. It counts cycles spent in NPU_RUN and restarts the
// count on every ack. It asserts expire for one cycle when TMO_CYC cycles
// pass without an ack. Only the NPU_TIMEOUT_EN build instantiates it.
module npu_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic ack,
  output logic expire
);

  // The count is 0 in the first NPU_RUN cycle, so expiry falls on cycle TMO_CYC.
  localparam logic [WD_W-1:0] LIMIT = WD_W'(TMO_CYC - 1);

  logic [WD_W-1:0] wd_cnt;

  // Cycle counter: held at zero outside NPU_RUN and restarted by each ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (!run || ack) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // An ack in the limit cycle counts as progress, so it suppresses expiry.
  assign expire = run & ~ack & (wd_cnt == LIMIT);

endmodule

// File: rtl/id_ex_flush_ctrl.sv
// ID/EX flush controller. It zeroes the ID/EX control bundle on a branch
// mispredict and for FLUSH_CYC-1 more cycles. It also sequences multi-cycle
// NPU operations, stalling IF/ID until MATR_N acks arrive.
// Optional feature: define NPU_TIMEOUT_EN to add the npu_watchdog abort path
// and the npu_tmo pulse. Without it, npu_tmo is tied low.
module id_ex_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W    = 6,
  parameter int FLUSH_CYC = 1,
  parameter int MATR_N    = 2,
  parameter int TMO_CYC   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              hit,
  input  logic [CTRL_W-1:0] id_ex_ctrl,
  input  logic              en_npu,
  input  logic              ack,
  output logic [CTRL_W-1:0] id_ex_f_ctrl,
  output logic              bubble,
  output logic              stall_if_id,
  output logic              npu_busy,
  output logic              npu_tmo
);

  localparam cnt_t FLUSH_LOAD = cnt_t'(FLUSH_CYC - 1);
  localparam cnt_t ACK_LAST   = cnt_t'(MATR_N - 1);

  state_t state;
  cnt_t   flush_cnt;
  cnt_t   ack_cnt;
  logic   mispredict;
  logic   zero_ctrl;
  logic   npu_run;
  logic   wd_expire;

  assign mispredict = flush & ~hit;
  assign npu_run    = (state == NPU_RUN);

  // The zeroing path is purely combinational, so the mispredict cycle and the
  // en_npu request cycle are squashed without waiting for a state change.
  // The path stays live during reset, because reset forces state to IDLE.
  assign zero_ctrl    = mispredict | ((state == IDLE) & en_npu) | (state != IDLE);
  assign id_ex_f_ctrl = zero_ctrl ? '0 : id_ex_ctrl;
  assign bubble       = zero_ctrl;

  // These outputs decode only the state register, so they carry no input-to-output path.
  assign stall_if_id = npu_run;
  assign npu_busy    = npu_run;

`ifdef NPU_TIMEOUT_EN
  // Watchdog aborts an NPU sequence whose acks stop arriving.
  npu_watchdog #(
    .TMO_CYC(TMO_CYC)
  ) u_npu_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (npu_run),
    .ack    (ack),
    .expire (wd_expire)
  );
  assign npu_tmo = wd_expire;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_CYC;
  assign wd_expire      = 1'b0;
  assign npu_tmo        = 1'b0;
`endif

  // Control FSM: IDLE -> FLUSH for multi-cycle bubbles, IDLE -> NPU_RUN for sequences.
  // NOTE: state and counters are flops, so they use non-blocking (<=) assignments.
  // Each flop also gets an explicit reset value, so no cycle starts from X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
      ack_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // A mispredict squashes a same-cycle en_npu; that start came from the wrong path.
          if (mispredict) begin
            if (FLUSH_CYC > 1) begin
              flush_cnt <= FLUSH_LOAD;
              state     <= FLUSH;
            end
          end else if (en_npu) begin
            ack_cnt <= '0;
            state   <= NPU_RUN;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - 1'b1;
          if (flush_cnt == cnt_t'(1)) begin
            state <= IDLE;
          end
        end
        NPU_RUN: begin
          if (ack) begin
            ack_cnt <= ack_cnt + 1'b1;
            if (ack_cnt == ACK_LAST) begin
              state <= IDLE;
            end
          end else if (wd_expire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_flush_ctrl.sv
// Testbench for id_ex_flush_ctrl. Two instances share one stimulus stream:
// dut_a uses FLUSH_CYC=3 and dut_b uses FLUSH_CYC=1.
// A behavioural model tracks, for each instance, the bubble cycles left,
// whether an NPU sequence is active, and the acks still owed.
// The bench checks every cycle against that model, plus fixed scenarios with literal expectations.
module tb_id_ex_flush_ctrl;

  localparam int CTRL_W  = 6;
  localparam int MATR_N  = 2;
  localparam int TMO_CYC = 10;
  localparam int FC_A    = 3;
  localparam int FC_B    = 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              hit = 1'b0;
  logic              en_npu = 1'b0;
  logic              ack = 1'b0;
  logic [CTRL_W-1:0] id_ex_ctrl = '0;

  logic [CTRL_W-1:0] f_ctrl_a, f_ctrl_b;
  logic              bubble_a, bubble_b;
  logic              stall_a, stall_b;
  logic              busy_a, busy_b;
  logic              tmo_a, tmo_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_flush_ctrl #(
    .CTRL_W(CTRL_W), .FLUSH_CYC(FC_A), .MATR_N(MATR_N), .TMO_CYC(TMO_CYC)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(flush), .hit(hit),
    .id_ex_ctrl(id_ex_ctrl), .en_npu(en_npu), .ack(ack),
    .id_ex_f_ctrl(f_ctrl_a), .bubble(bubble_a), .stall_if_id(stall_a),
    .npu_busy(busy_a), .npu_tmo(tmo_a)
  );

  id_ex_flush_ctrl #(
    .CTRL_W(CTRL_W), .FLUSH_CYC(FC_B), .MATR_N(MATR_N), .TMO_CYC(TMO_CYC)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(flush), .hit(hit),
    .id_ex_ctrl(id_ex_ctrl), .en_npu(en_npu), .ack(ack),
    .id_ex_f_ctrl(f_ctrl_b), .bubble(bubble_b), .stall_if_id(stall_b),
    .npu_busy(busy_b), .npu_tmo(tmo_b)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int flush_left;  // further bubble cycles owed after the mispredict cycle
    bit npu_on;      // NPU sequence in progress
    int acks_left;   // acks still needed to finish the sequence
    int wd;          // cycles since sequence start or last ack
  } mdl_t;

  mdl_t ma, mb;

  function automatic bit m_idle(mdl_t m);
    return (m.flush_left == 0) && !m.npu_on;
  endfunction

  function automatic bit m_zero(mdl_t m);
    return (flush && !hit) || (m_idle(m) && en_npu) || !m_idle(m);
  endfunction

  function automatic bit m_tmo(mdl_t m);
`ifdef NPU_TIMEOUT_EN
    return m.npu_on && !ack && (m.wd == TMO_CYC - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic mdl_t m_next(mdl_t m, int fc);
    mdl_t n = m;
    if (m_idle(m)) begin
      if (flush && !hit) begin
        n.flush_left = fc - 1;
      end else if (en_npu) begin
        n.npu_on    = 1'b1;
        n.acks_left = MATR_N;
        n.wd        = 0;
      end
    end else if (m.flush_left > 0) begin
      n.flush_left = m.flush_left - 1;
    end else begin
      if (ack) begin
        n.acks_left = m.acks_left - 1;
        n.wd        = 0;
        if (n.acks_left == 0) n.npu_on = 1'b0;
      end else if (m_tmo(m)) begin
        n.npu_on = 1'b0;
      end else begin
        n.wd = m.wd + 1;
      end
    end
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input string tag, input mdl_t m, input logic [CTRL_W-1:0] f,
                         input logic b, input logic st, input logic bu, input logic tm);
    logic [CTRL_W-1:0] exp_f;
    exp_f = m_zero(m) ? '0 : id_ex_ctrl;
    check({tag, ".f_ctrl"}, 32'(f), 32'(exp_f));
    check({tag, ".bubble"}, 32'(b), 32'(m_zero(m)));
    check({tag, ".stall"}, 32'(st), 32'(m.npu_on));
    check({tag, ".busy"}, 32'(bu), 32'(m.npu_on));
    check({tag, ".tmo"}, 32'(tm), 32'(m_tmo(m)));
  endtask

  task automatic cmp();
    cmp_one("a", ma, f_ctrl_a, bubble_a, stall_a, busy_a, tmo_a);
    cmp_one("b", mb, f_ctrl_b, bubble_b, stall_b, busy_b, tmo_b);
  endtask

  // Drive inputs on the falling edge, then compare once the combinational outputs settle.
  task automatic drive(input bit f, input bit h, input bit e, input bit a,
                       input logic [CTRL_W-1:0] c);
    @(negedge clk);
    flush = f; hit = h; en_npu = e; ack = a; id_ex_ctrl = c;
    #1 cmp();
  endtask

  // Let the rising edge consume the driven inputs, and step both models to match.
  task automatic adv();
    @(posedge clk);
    ma = m_next(ma, FC_A);
    mb = m_next(mb, FC_B);
  endtask

  // Mid-cycle asynchronous reset pulse that spans one rising edge.
  task automatic pulse_reset();
    #1;
    flush = 1'b0; hit = 1'b0; en_npu = 1'b0; ack = 1'b0;
    reset_n = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};
    #1;
    check("rst.busy_a", 32'(busy_a), 32'd0);
    check("rst.busy_b", 32'(busy_b), 32'd0);
    cmp();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ma = '{default: 0};
    mb = '{default: 0};

    // Reset state: while reset is held, the combinational path stays live.
    id_ex_ctrl = 6'h2D;
    #1;
    check("reset.f_ctrl", 32'(f_ctrl_a), 32'h2D);
    check("reset.bubble", 32'(bubble_a), 32'd0);
    check("reset.busy", 32'(busy_a), 32'd0);
    check("reset.stall", 32'(stall_a), 32'd0);
    check("reset.tmo", 32'(tmo_a), 32'd0);
    flush = 1'b1; hit = 1'b0;
    #1;
    check("reset.mispredict_f", 32'(f_ctrl_a), 32'h0);
    check("reset.mispredict_b", 32'(bubble_a), 32'd1);
    flush = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Mispredict with FLUSH_CYC=3 on dut_a; dut_b (FLUSH_CYC=1) recovers after one cycle.
    drive(1, 0, 0, 0, 6'h3F);
    check("flush3.c0", 32'(f_ctrl_a), 32'h0);
    check("flush1.c0", 32'(f_ctrl_b), 32'h0);
    adv();
    drive(0, 0, 0, 0, 6'h3F);
    check("flush3.c1", 32'(f_ctrl_a), 32'h0);
    check("flush1.c1", 32'(f_ctrl_b), 32'h3F);
    adv();
    drive(0, 0, 0, 0, 6'h3F);
    check("flush3.c2", 32'(f_ctrl_a), 32'h0);
    adv();
    drive(0, 0, 0, 0, 6'h3F);
    check("flush3.c3", 32'(f_ctrl_a), 32'h3F);
    adv();

    // Correct prediction: the resolved flush passes the bundle through.
    drive(1, 1, 0, 0, 6'h15);
    check("hit.f_ctrl", 32'(f_ctrl_a), 32'h15);
    check("hit.bubble", 32'(bubble_a), 32'd0);
    adv();
    drive(0, 0, 0, 0, 6'h15);
    check("hit.busy", 32'(busy_a), 32'd0);
    check("hit.f_next", 32'(f_ctrl_a), 32'h15);
    adv();

    // NPU sequence: en_npu in cycle 0, acks in cycles 5 and 9.
    drive(0, 0, 1, 0, 6'h2A);
    check("npu.c0_f", 32'(f_ctrl_a), 32'h0);
    check("npu.c0_stall", 32'(stall_a), 32'd0);
    adv();
    for (int c = 1; c <= 9; c++) begin
      drive(0, 0, 0, (c == 5 || c == 9), 6'h2A);
      check($sformatf("npu.c%0d_stall", c), 32'(stall_a), 32'd1);
      check($sformatf("npu.c%0d_f", c), 32'(f_ctrl_a), 32'h0);
      adv();
    end
    drive(0, 0, 0, 0, 6'h2A);
    check("npu.c10_stall", 32'(stall_a), 32'd0);
    check("npu.c10_f", 32'(f_ctrl_a), 32'h2A);
    adv();

    // en_npu together with a mispredict: the mispredict wins, and dut_b gives one bubble.
    drive(1, 0, 1, 0, 6'h2A);
    check("prio.c0_bubble", 32'(bubble_b), 32'd1);
    adv();
    drive(0, 0, 0, 0, 6'h2A);
    check("prio.c1_busy", 32'(busy_b), 32'd0);
    check("prio.c1_bubble", 32'(bubble_b), 32'd0);
    check("prio.c1_f", 32'(f_ctrl_b), 32'h2A);
    adv();
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 0, 6'h2A);
      adv();
    end

    // Reset in the fourth NPU_RUN cycle abandons the sequence.
    drive(0, 0, 1, 0, 6'h11);
    adv();
    for (int c = 1; c <= 4; c++) begin
      drive(0, 0, 0, 0, 6'h11);
      check($sformatf("rstnpu.c%0d_busy", c), 32'(busy_a), 32'd1);
      if (c < 4) adv();
    end
    pulse_reset();
    drive(0, 0, 0, 0, 6'h11);
    check("rstnpu.after_f", 32'(f_ctrl_a), 32'h11);
    check("rstnpu.after_busy", 32'(busy_a), 32'd0);
    adv();

`ifdef NPU_TIMEOUT_EN
    // Watchdog: with no acks, expiry falls on NPU_RUN cycle TMO_CYC.
    drive(0, 0, 1, 0, 6'h01);
    adv();
    for (int c = 1; c <= TMO_CYC; c++) begin
      drive(0, 0, 0, 0, 6'h01);
      check($sformatf("tmo.c%0d", c), 32'(tmo_a), 32'(c == TMO_CYC));
      adv();
    end
    drive(0, 0, 0, 0, 6'h01);
    check("tmo.after_busy", 32'(busy_a), 32'd0);
    adv();
`endif

    // Randomised traffic, checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        drive(0, 0, 0, 0, 6'($urandom));
        pulse_reset();
      end else begin
        drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
              6'($urandom));
        adv();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
